serv_rf_ram_resp: RTL and testbench
===================================

// Module: serv_rf_ram_resp
// PURPOSE
//  RAM-side responder for the bit-serial register-file RAM interface:
//  services the waddr/wdata/wen and raddr/ren requests from the SERV
//  register-file interface with a width-wide register/CSR store.
//  Zeroes the whole store after every reset with a sequencer.
//  Returns registered read data one cycle after ren and guards x0 rows.
//  Sits between the serv_rf_ram_if request side and the core's top level.
// PARAMETERS
//  width     8   data width of the RAM port; must be 2,4,8,16 or 32
//  csr_regs  4   CSR registers stored after the 32 GPRs
//  x0_guard  1   1: writes to any x0 word are dropped
//  bypass    0   1: same-cycle same-address read returns new write data
//  depth     (32+csr_regs)*(32/width)  number of words (derived, do not set)
//  aw        5+$clog2(32+csr_regs)-$clog2(width)  address width (derived)
// PORTS
//  i_clk        in   1      clock; all state changes on rising edge
//  i_rst        in   1      asynchronous reset, active-high
//  i_waddr      in   aw     write word address {reg, word index}
//  i_wdata      in   width  write data
//  i_wen        in   1      write enable
//  i_raddr      in   aw     read word address {reg, word index}
//  i_ren        in   1      read enable
//  o_rdata      out  width  registered read data
//  o_init_done  out  1      high once the clear sequence has finished
// BEHAVIOUR
//  Reset (async, any time): state<=CLEAR, clr_cnt<=0, o_rdata<=0,
//   o_init_done<=0. Memory is not reset directly; CLEAR rewrites it.
//  FSM states: CLEAR, READY.
//   CLEAR: each cycle mem[clr_cnt]<=0, clr_cnt<=clr_cnt+1. On the cycle
//    clr_cnt==depth-1 the last word is written and state<=READY.
//    CLEAR lasts exactly depth cycles after reset deasserts.
//    i_wen/i_ren are ignored and o_rdata holds 0.
//   READY: o_init_done=1 (registered: first high cycle is the first
//    READY cycle). No exit except reset.
//  Write (READY): i_wen=1 -> mem[i_waddr]<=i_wdata at the edge.
//   Dropped if i_waddr>=depth, or if x0_guard=1 and i_waddr<32/width.
//  Read (READY): i_ren=1 -> o_rdata<=mem[i_raddr] at the edge.
//   Latency is 1 cycle. i_raddr>=depth returns 0.
//   i_ren=0 -> o_rdata holds its last value.
//  Read/write collision (same edge, i_raddr==i_waddr, write not dropped):
//   bypass=1 -> o_rdata<=i_wdata. bypass=0 -> o_rdata<=old contents.
//   Dropped write: o_rdata<=stored contents in both modes.
//  Different addresses on the same edge are fully independent.
//  Reset during CLEAR restarts the sequence at word 0. Reset in READY
//   discards the contents; all words read 0 after the next CLEAR.
//  Address arithmetic is unsigned. The clr_cnt width is aw; it never wraps
//   because it stops at depth-1.
// TESTING
//  1 Release reset (width=8,csr=4): o_init_done=0 for 144 cycles, then 1;
//    reads of addr 0..143 all return 8'h00.
//  2 Write 8'hA5 to 8'd20; next edge ren at 20 -> o_rdata=8'hA5 one
//    cycle after ren; ren=0 afterwards -> o_rdata stays 8'hA5.
//  3 x0_guard=1: write 8'hFF to addr 2, read addr 2 -> 8'h00; x0_guard=0
//    -> 8'hFF. Write to addr 150 dropped; read 150 -> 8'h00.
//  4 Collision: mem[40]=8'h11, same-edge wen 8'h22 and ren at 40 ->
//    bypass=0 gives 8'h11, bypass=1 gives 8'h22; both give 8'h22 on reread.
//  5 Assert i_rst 50 cycles into CLEAR: o_init_done stays 0, and 144 more
//    cycles pass before it rises; ren/wen during CLEAR have no effect.
//  6 Write 8'h3C to addr 100 in READY, pulse i_rst mid-cycle: o_rdata=0
//    immediately (async); after CLEAR, read 100 -> 8'h00.

Source files
------------

// File: rtl/serv_rf_ram_resp.sv
// RAM-side responder for the SERV bit-serial register-file RAM interface.
// Holds the GPR/CSR store and clears every word after each reset. Reads
// return registered data one cycle after ren. Writes to x0 rows can be
// dropped.
module serv_rf_ram_resp #(
  parameter  int width    = 8,
  parameter  int csr_regs = 4,
  parameter  int x0_guard = 1,
  parameter  int bypass   = 0,
  localparam int depth    = (32 + csr_regs) * (32 / width),
  localparam int aw       = 5 + $clog2(32 + csr_regs) - $clog2(width)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [aw-1:0]    i_waddr,
  input  logic [width-1:0] i_wdata,
  input  logic             i_wen,
  input  logic [aw-1:0]    i_raddr,
  input  logic             i_ren,
  output logic [width-1:0] o_rdata,
  output logic             o_init_done
);

  typedef enum logic {CLEAR, READY} state_t;

  // Address limits widened by one bit so that depth itself is representable.
  localparam logic [aw:0]   DEPTH_W = (aw+1)'(depth);
  localparam logic [aw:0]   X0_W    = (aw+1)'(32 / width);
  localparam logic [aw-1:0] LAST    = aw'(depth - 1);

  state_t            state, state_nxt;
  logic [aw-1:0]     clr_cnt, clr_nxt;
  logic [width-1:0]  mem [depth];

  logic              waddr_ok, raddr_ok, x0_hit, wr_ok, rd_en;
  logic              mem_we;
  logic [aw-1:0]     mem_wa;
  logic [width-1:0]  mem_wd, rd_val;

  // Clear sequencer: walk clr_cnt over every word, then park in READY.
  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST) state_nxt = READY;
        else                 clr_nxt   = clr_cnt + aw'(1);
      end
      default: ;
    endcase
  end

  // Request decode: qualify the write, pick the memory write port source,
  // and form the read value including the optional write-through path.
  always_comb begin
    waddr_ok = {1'b0, i_waddr} < DEPTH_W;
    raddr_ok = {1'b0, i_raddr} < DEPTH_W;
    x0_hit   = (x0_guard != 0) && ({1'b0, i_waddr} < X0_W);
    wr_ok    = (state == READY) && i_wen && waddr_ok && !x0_hit;
    rd_en    = (state == READY) && i_ren;

    mem_we = (state == CLEAR) || wr_ok;
    mem_wa = (state == CLEAR) ? clr_cnt : i_waddr;
    mem_wd = (state == CLEAR) ? '0 : i_wdata;

    // A dropped write never forwards; the stored word is returned instead.
    if (!raddr_ok)
      rd_val = '0;
    else if ((bypass != 0) && wr_ok && (i_raddr == i_waddr))
      rd_val = i_wdata;
    else
      rd_val = mem[i_raddr];
  end

  // Storage array: no reset, its contents are rewritten by the CLEAR walk.
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // Control state and registered read port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      o_rdata     <= '0;
      o_init_done <= 1'b0;
    end else begin
      state       <= state_nxt;
      clr_cnt     <= clr_nxt;
      o_init_done <= (state_nxt == READY);
      if (rd_en) o_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_serv_rf_ram_resp.sv
// Bench for serv_rf_ram_resp: two instances (guard/no-bypass and
// no-guard/bypass) share stimulus; expected read data is queued per
// instance and a monitor checks it one cycle after each read.
module tb_serv_rf_ram_resp;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          wen = 1'b0, ren = 1'b0;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          done_a, done_b;
  logic          exp_flag = 1'b0;

  logic [DW-1:0] q_a[$];
  logic [DW-1:0] q_b[$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serv_rf_ram_resp #(.width(8), .csr_regs(4), .x0_guard(1), .bypass(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
    .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata_a), .o_init_done(done_a));

  serv_rf_ram_resp #(.width(8), .csr_regs(4), .x0_guard(0), .bypass(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_waddr(waddr), .i_wdata(wdata), .i_wen(wen),
    .i_raddr(raddr), .i_ren(ren), .o_rdata(rdata_b), .o_init_done(done_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One stimulus cycle driven at the falling edge; push=1 queues expectations.
  task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra,
                     input logic push, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    @(negedge clk);
    wen = we; waddr = wa; wdata = wd; ren = re; raddr = ra;
    exp_flag = push;
    if (push) begin
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc(1'b1, a, d, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
    cyc(1'b0, '0, '0, 1'b1, a, 1'b1, ea, eb);
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Counts rising edges from reset release until init_done, bounded.
  task automatic wait_init(input string name);
    int n = 0;
    while (!done_a && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " clear_cycles"}, n, 144);
    check({name, " done_b"}, done_b, 1);
  endtask

  // Monitor: compares both instances one cycle after a queued request.
  initial begin
    logic f;
    logic [DW-1:0] ea, eb;
    forever begin
      @(posedge clk);
      f = exp_flag;
      #1;
      if (f) begin
        if (q_a.size() == 0 || q_b.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL monitor: queue empty on expected read");
        end else begin
          ea = q_a.pop_front();
          eb = q_b.pop_front();
          check("rdata_a", rdata_a, ea);
          check("rdata_b", rdata_b, eb);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst rdata_a", rdata_a, 0);
    check("rst done_a", done_a, 0);
    check("rst done_b", done_b, 0);
    rst = 1'b0;
    wait_init("t1");

    // Whole store clear
    for (int a = 0; a < 144; a++) rd(a[AW-1:0], 8'h00, 8'h00);
    idle();

    // Basic write/read and hold
    wr(8'd20, 8'hA5);
    rd(8'd20, 8'hA5, 8'hA5);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'hA5, 8'hA5);
    cyc(1'b0, '0, '0, 1'b0, '0, 1'b1, 8'hA5, 8'hA5);

    // x0 guard and out-of-range addresses
    wr(8'd2, 8'hFF);
    rd(8'd2, 8'h00, 8'hFF);
    wr(8'd3, 8'h12);
    rd(8'd3, 8'h00, 8'h12);
    wr(8'd4, 8'h34);
    rd(8'd4, 8'h34, 8'h34);
    wr(8'd150, 8'h77);
    rd(8'd150, 8'h00, 8'h00);
    wr(8'd143, 8'h9E);
    rd(8'd143, 8'h9E, 8'h9E);
    wr(8'd144, 8'h66);
    rd(8'd144, 8'h00, 8'h00);

    // Collisions
    wr(8'd40, 8'h11);
    cyc(1'b1, 8'd40, 8'h22, 1'b1, 8'd40, 1'b1, 8'h11, 8'h22);
    rd(8'd40, 8'h22, 8'h22);
    cyc(1'b1, 8'd1, 8'h07, 1'b1, 8'd1, 1'b1, 8'h00, 8'h07);
    rd(8'd1, 8'h00, 8'h07);
    // Different addresses on the same edge
    cyc(1'b1, 8'd60, 8'h55, 1'b1, 8'd20, 1'b1, 8'hA5, 8'hA5);
    rd(8'd60, 8'h55, 8'h55);
    idle();

    // Reset 50 cycles into CLEAR, requests during CLEAR ignored
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("clr rdata_a", rdata_a, 0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      wen = 1'b1; waddr = 8'd20; wdata = 8'hEE; ren = 1'b1; raddr = 8'd60;
      @(posedge clk); #1;
      if (i % 10 == 9) begin
        check("clr done_a", done_a, 0);
        check("clr rdata_a", rdata_a, 0);
        check("clr rdata_b", rdata_b, 0);
      end
    end
    @(negedge clk);
    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    @(negedge clk); rst = 1'b0;
    check("rst2 done_a", done_a, 0);
    wait_init("t5");
    rd(8'd20, 8'h00, 8'h00);
    rd(8'd60, 8'h00, 8'h00);

    // Asynchronous reset in READY
    wr(8'd100, 8'h3C);
    rd(8'd100, 8'h3C, 8'h3C);
    idle();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async rdata_a", rdata_a, 0);
    check("async rdata_b", rdata_b, 0);
    check("async done_a", done_a, 0);
    @(negedge clk); rst = 1'b0;
    wait_init("t6");
    rd(8'd100, 8'h00, 8'h00);
    idle();
    idle();
    idle();
    check("queue_a drained", q_a.size(), 0);
    check("queue_b drained", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
